// File: rtl/wb_ram_mp.sv
// ---------------------------------------------------------------------------
// wb_ram_mp -- N-port Wishbone classic RAM with a registered arbiter.
//
// NPORTS masters share one single-port storage array. Each cycle one
// requesting port is granted: round-robin (ARB_RR=1) or lowest index first
// (ARB_RR=0). The granted access executes on the closing clock edge, and the
// winner sees a one-cycle ack (or err for an out-of-range address) in the
// following cycle.
//
// Ports (port i of a packed bus sits at [i*W +: W]):
//   wb_clk      in   bus clock, rising edge
//   wb_reset_n  in   asynchronous active-low reset
//   wb_cyc_i    in   [NPORTS]          bus cycle per port
//   wb_stb_i    in   [NPORTS]          strobe per port
//   wb_we_i     in   [NPORTS]          write enable per port
//   wb_sel_i    in   [NPORTS*SEL_W]    byte-lane selects
//   wb_adr_i    in   [NPORTS*ADDR_W]   byte addresses
//   wb_dat_i    in   [NPORTS*DATA_W]   write data
//   wb_dat_o    out  [NPORTS*DATA_W]   read data, valid while that ack is high
//   wb_ack_o    out  [NPORTS]          one-cycle acknowledge
//   wb_err_o    out  [NPORTS]          one-cycle error (address out of range)
// ---------------------------------------------------------------------------
module wb_ram_mp #(
  parameter int NPORTS = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int ARB_RR = 1
) (
  input  logic                       wb_clk,
  input  logic                       wb_reset_n,
  input  logic [NPORTS-1:0]          wb_cyc_i,
  input  logic [NPORTS-1:0]          wb_stb_i,
  input  logic [NPORTS-1:0]          wb_we_i,
  input  logic [NPORTS*DATA_W/8-1:0] wb_sel_i,
  input  logic [NPORTS*ADDR_W-1:0]   wb_adr_i,
  input  logic [NPORTS*DATA_W-1:0]   wb_dat_i,
  output logic [NPORTS*DATA_W-1:0]   wb_dat_o,
  output logic [NPORTS-1:0]          wb_ack_o,
  output logic [NPORTS-1:0]          wb_err_o
);

  localparam int SEL_W  = DATA_W / 8;
  localparam int LSB    = (SEL_W > 1) ? $clog2(SEL_W) : 0;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << LSB) - 64'd1);

  logic [NPORTS-1:0]        r_ack;
  logic [NPORTS-1:0]        r_err;
  logic [NPORTS*DATA_W-1:0] r_dat;
  logic [PTR_W-1:0]         r_ptr;
  logic [DATA_W-1:0]        r_mem [DEPTH];

  logic [NPORTS-1:0] w_req;
  logic [NPORTS-1:0] w_rot;
  logic [PTR_W-1:0]  w_shift;
  logic              w_gnt;
  logic [PTR_W-1:0]  w_win;
  logic              w_we;
  logic [SEL_W-1:0]  w_sel;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_wdat;
  logic              w_oor;
  logic [MEM_AW-1:0] w_idx;

  // (base + off) mod NPORTS, off < NPORTS
  function automatic logic [PTR_W-1:0] f_wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NPORTS) s = s - NPORTS;
    return PTR_W'(s);
  endfunction

  // A port in its ack/err cycle is masked so a held request is not served twice.
  assign w_req   = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_shift = (ARB_RR != 0) ? r_ptr : '0;

  // Rotate the request vector so bit 0 is the highest-priority port, then
  // pick the lowest set bit and map it back to a port index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise a latch is inferred.
    w_rot = NPORTS'({w_req, w_req} >> w_shift);
    w_gnt = 1'b0;
    w_win = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_gnt = 1'b1;
        w_win = f_wrap_add(w_shift, k);
      end
    end
  end

  // Route the winner's request fields to the shared access path.
  always_comb begin
    w_we   = 1'b0;
    w_sel  = '0;
    w_adr  = '0;
    w_wdat = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (w_win == PTR_W'(i)) begin
        w_we   = wb_we_i[i];
        w_sel  = wb_sel_i[i*SEL_W +: SEL_W];
        w_adr  = wb_adr_i[i*ADDR_W +: ADDR_W];
        w_wdat = wb_dat_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Out of range: word beyond DEPTH, or a sub-word offset with no lane selected.
  assign w_oor = ((w_adr >> LSB) >= ADDR_W'(DEPTH)) ||
                 (((w_adr & LOW_MASK) != '0) && (w_sel == '0));
  assign w_idx = MEM_AW'(w_adr >> LSB);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk or negedge wb_reset_n) begin
    if (!wb_reset_n) begin
      r_ack <= '0;
      r_err <= '0;
      r_dat <= '0;
      r_ptr <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      if (w_gnt) begin
        r_ptr <= f_wrap_add(w_win, 1);
        for (int i = 0; i < NPORTS; i++) begin
          if (w_win == PTR_W'(i)) begin
            if (w_oor) begin
              r_err[i]                  <= 1'b1;
              r_dat[i*DATA_W +: DATA_W] <= '0;
            end else begin
              r_ack[i] <= 1'b1;
              if (!w_we) r_dat[i*DATA_W +: DATA_W] <= r_mem[w_idx];
            end
          end
        end
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive reset and the
  // array maps onto plain RAM. Writes are blocked while reset is held.
  always_ff @(posedge wb_clk) begin
    if (wb_reset_n && w_gnt && w_we && !w_oor) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (w_sel[b]) r_mem[w_idx][b*8 +: 8] <= w_wdat[b*8 +: 8];
      end
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_dat_o = r_dat;

endmodule

// File: tb/tb_wb_ram_mp.sv
// ---------------------------------------------------------------------------
// tb_wb_ram_mp -- scoreboard bench for wb_ram_mp (3 ports, 32-bit, 256 words).
// A round-robin instance carries the scoreboarded traffic; a fixed-priority
// instance with its own cyc/stb is used for the priority scenario.
// ---------------------------------------------------------------------------
module tb_wb_ram_mp;

  localparam int NP = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NP-1:0]     cyc, stb, we, fp_cyc, fp_stb;
  logic [NP*SW-1:0]  sel;
  logic [NP*AW-1:0]  adr;
  logic [NP*DW-1:0]  wdat;
  logic [NP*DW-1:0]  rr_dat, fp_dat;
  logic [NP-1:0]     rr_ack, rr_err, fp_ack, fp_err;

  wb_ram_mp #(.NPORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .ARB_RR(1)) dut_rr (
    .wb_clk(clk), .wb_reset_n(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(rr_dat), .wb_ack_o(rr_ack), .wb_err_o(rr_err)
  );

  wb_ram_mp #(.NPORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .ARB_RR(0)) dut_fp (
    .wb_clk(clk), .wb_reset_n(rst_n),
    .wb_cyc_i(fp_cyc), .wb_stb_i(fp_stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(fp_dat), .wb_ack_o(fp_ack), .wb_err_o(fp_err)
  );

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q [NP][$];
  int   gnt_log[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every response on the round-robin instance pops its port's queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int p = 0; p < NP; p++) begin
        if (rr_ack[p] || rr_err[p]) begin
          gnt_log.push_back(p);
          if (exp_q[p].size() == 0) begin
            check($sformatf("unexpected_rsp_p%0d", p), 32'd1, 32'd0);
          end else begin
            e = exp_q[p].pop_front();
            check($sformatf("rsp_err_p%0d", p), 32'(rr_err[p]), 32'(e.err));
            check($sformatf("rsp_ack_p%0d", p), 32'(rr_ack[p]), 32'(!e.err));
            if (e.chk) check($sformatf("rsp_dat_p%0d", p), rr_dat[p*DW +: DW], e.dat);
          end
        end
      end
    end
  end

  // One transfer on port p: push the expected response, hold the request
  // until ack/err, then drop it. lat = clock edges from request to response.
  task automatic bus_op(input int p, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_dat, output int lat);
    exp_t e;
    int   n;
    e.err = e_err;
    e.chk = !w || e_err;
    e.dat = e_dat;
    exp_q[p].push_back(e);
    @(posedge clk); #1;
    cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = w;
    sel[p*SW +: SW] = s; adr[p*AW +: AW] = a; wdat[p*DW +: DW] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rr_ack[p] || rr_err[p]) && n < 20);
    if (!(rr_ack[p] || rr_err[p])) check($sformatf("timeout_p%0d", p), 32'd0, 32'd1);
    @(posedge clk); #1;
    cyc[p] = 1'b0; stb[p] = 1'b0;
    lat = n - 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0; fp_cyc = '0; fp_stb = '0;
    sel = '0; adr = '0; wdat = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(rr_ack), 32'd0);
    check("rst_err", 32'(rr_err), 32'd0);
    for (int p = 0; p < NP; p++) check($sformatf("rst_dat_p%0d", p), rr_dat[p*DW +: DW], 32'd0);
    check("rst_fp_ack", 32'(fp_ack), 32'd0);
    rst_n = 1'b1;

    // Round-robin: all ports write continuously for 12 grant cycles
    gnt_log.delete();
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) begin
      exp_t e;
      e.err = 1'b0; e.chk = 1'b0; e.dat = '0;
      for (int r = 0; r < 4; r++) exp_q[p].push_back(e);
      cyc[p] = 1'b1; stb[p] = 1'b1; we[p] = 1'b1;
      sel[p*SW +: SW] = 4'hF; adr[p*AW +: AW] = 32'(p * 4);
      wdat[p*DW +: DW] = 32'hA5A5_0000 + 32'(p);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("rr_acks_cycle%0d", k), 32'($countones(rr_ack)), (k == 0) ? 32'd0 : 32'd1);
    end
    @(posedge clk); #1;
    cyc = '0; stb = '0;
    @(negedge clk);
    check("rr_acks_cycle12", 32'($countones(rr_ack)), 32'd1);
    @(posedge clk); #1;
    check("rr_grant_count", 32'(gnt_log.size()), 32'd12);
    for (int i = 0; i < gnt_log.size(); i++)
      check($sformatf("rr_order_%0d", i), 32'(gnt_log[i]), 32'(i % NP));
    for (int p = 0; p < NP; p++)
      bus_op(p, 1'b0, 32'(p * 4), 4'h0, 32'd0, 1'b0, 32'hA5A5_0000 + 32'(p), lat);

    // Single-port write/read with latency
    bus_op(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'd0, lat);
    check("wr_latency", 32'(lat), 32'd1);
    bus_op(0, 1'b0, 32'h10, 4'hF, 32'd0, 1'b0, 32'hDEAD_BEEF, lat);
    check("rd_latency", 32'(lat), 32'd1);

    // Byte lanes, then a sel=0 write that must leave memory unchanged
    bus_op(1, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b0, 32'd0, lat);
    bus_op(1, 1'b1, 32'h20, 4'hA, 32'hAA00_BB00, 1'b0, 32'd0, lat);
    bus_op(1, 1'b0, 32'h20, 4'hF, 32'd0, 1'b0, 32'hAA22_BB44, lat);
    bus_op(2, 1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'd0, lat);
    bus_op(2, 1'b0, 32'h20, 4'h0, 32'd0, 1'b0, 32'hAA22_BB44, lat);

    // Out of range: read and write at byte 0x400, word 0 untouched
    bus_op(2, 1'b0, 32'h400, 4'hF, 32'd0, 1'b1, 32'd0, lat);
    bus_op(2, 1'b1, 32'h400, 4'hF, 32'hCAFE_F00D, 1'b1, 32'd0, lat);
    bus_op(0, 1'b0, 32'h0, 4'hF, 32'd0, 1'b0, 32'hA5A5_0000, lat);

    // Fixed priority: ports 1 and 2 request continuously
    @(posedge clk); #1;
    we = '0; adr = '0;
    fp_cyc = 3'b110; fp_stb = 3'b110;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("fp_rsp_cycle%0d", k), 32'({fp_err, fp_ack}),
            (k == 0) ? 32'h0 : ((k % 2) == 1) ? 32'h2 : 32'h4);
    end
    @(posedge clk); #1;
    fp_cyc = '0; fp_stb = '0;
    repeat (2) @(posedge clk);

    // Reset while a granted write is in its ack cycle
    #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[3:0] = 4'hF;
    adr[31:0] = 32'h30; wdat[31:0] = 32'h1234_5678;
    @(posedge clk); #1;
    check("pre_rst_ack", 32'(rr_ack), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(rr_ack), 32'd0);
    check("mid_rst_err", 32'(rr_err), 32'd0);
    check("mid_rst_dat0", rr_dat[31:0], 32'd0);
    cyc = '0; stb = '0; we = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gnt_log.delete();
    fork
      bus_op(0, 1'b0, 32'h30, 4'hF, 32'd0, 1'b0, 32'h1234_5678, lat);
      begin int l1; bus_op(1, 1'b0, 32'h30, 4'hF, 32'd0, 1'b0, 32'h1234_5678, l1); end
      begin int l2; bus_op(2, 1'b0, 32'h30, 4'hF, 32'd0, 1'b0, 32'h1234_5678, l2); end
    join
    check("post_rst_grants", 32'(gnt_log.size()), 32'd3);
    for (int i = 0; i < gnt_log.size(); i++)
      check($sformatf("post_rst_order_%0d", i), 32'(gnt_log[i]), 32'(i));

    repeat (2) @(posedge clk);
    for (int p = 0; p < NP; p++)
      check($sformatf("queue_empty_p%0d", p), 32'(exp_q[p].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
